// File: rtl/iob_fp_div_pkg.sv
// Shared floating-point package: format widths, bias, rounding extra bits,
// divider FSM state type and canonical Inf / zero / NaN encodings.
package iob_fp_div_pkg;

  localparam int DATA_W = 32;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = DATA_W - EXP_W;        // mantissa including hidden bit
  localparam int FRAC_W = MAN_W - 1;             // stored fraction bits
  localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
  localparam int EXTRA  = 3;                     // guard, round, sticky
  localparam int ITER   = MAN_W + EXTRA + 1;     // quotient bits produced
  localparam int Q_W    = ITER;
  localparam int RND_W  = MAN_W + EXTRA;         // mantissa + GRS fed to rounding
  localparam int EXPS_W = EXP_W + 2;             // signed working exponent
  localparam int CNT_W  = $clog2(ITER);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_NORM  = 2'd2,
    ST_ROUND = 2'd3
  } state_t;

  function automatic logic [DATA_W-1:0] fp_inf(input logic sign);
    return {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
  endfunction

  function automatic logic [DATA_W-1:0] fp_zero(input logic sign);
    return {sign, {(DATA_W-1){1'b0}}};
  endfunction

  function automatic logic [DATA_W-1:0] fp_qnan();
    return {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
  endfunction

endpackage

// File: rtl/iob_fp_round.sv
// Round-to-nearest-even on {exponent, mantissa+GRS}, then exponent range
// check: saturate to Inf on overflow, flush to signed zero on underflow.
module iob_fp_round
  import iob_fp_div_pkg::*;
(
  input  logic                     sign,
  input  logic signed [EXPS_W-1:0] exponent,
  input  logic [RND_W-1:0]         mantissa,
  output logic [DATA_W-1:0]        res,
  output logic                     overflow,
  output logic                     underflow
);

  localparam logic signed [EXPS_W-1:0] EXP_MAX = EXPS_W'((1 << EXP_W) - 1);
  localparam logic signed [EXPS_W-1:0] EXP_MIN = '0;

  logic [MAN_W-1:0]         mant;
  logic                     guard;
  logic                     round_bit;
  logic                     sticky;
  logic                     round_up;
  logic [MAN_W:0]           mant_r;
  logic [MAN_W-1:0]         mant_n;
  logic signed [EXPS_W-1:0] exp_n;
  logic                     unused_hidden;

  assign mant      = mantissa[RND_W-1 -: MAN_W];
  assign guard     = mantissa[EXTRA-1];
  assign round_bit = mantissa[EXTRA-2];
  assign sticky    = mantissa[0];

  // Round, renormalise a carry-out, then classify the final exponent.
  always_comb begin
    round_up  = guard & (round_bit | sticky | mant[0]);
    mant_r    = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};
    mant_n    = mant_r[MAN_W-1:0];
    exp_n     = exponent;
    if (mant_r[MAN_W]) begin
      mant_n = mant_r[MAN_W:1];
      exp_n  = exponent + EXPS_W'(1);
    end
    overflow  = 1'b0;
    underflow = 1'b0;
    res       = {sign, exp_n[EXP_W-1:0], mant_n[FRAC_W-1:0]};
    if (exp_n >= EXP_MAX) begin
      res      = fp_inf(sign);
      overflow = 1'b1;
    end else if (exp_n <= EXP_MIN) begin
      res       = fp_zero(sign);
      underflow = 1'b1;
    end
  end

  // Hidden bit is implicit in the packed format.
  assign unused_hidden = mant_n[MAN_W-1];

endmodule

// File: rtl/iob_fp_special.sv
// Operand classifier (NaN / Inf / zero). Only built when
// IOB_FP_DIV_SPECIAL_EN is defined; subnormals are not reported as zero.
`ifdef IOB_FP_DIV_SPECIAL_EN
module iob_fp_special
  import iob_fp_div_pkg::*;
(
  input  logic [DATA_W-1:0] op,
  output logic              is_nan,
  output logic              is_inf,
  output logic              is_zero
);

  logic exp_ones;
  logic exp_zero;
  logic frac_zero;
  logic unused_sign;

  assign exp_ones    = &op[DATA_W-2 -: EXP_W];
  assign exp_zero    = ~|op[DATA_W-2 -: EXP_W];
  assign frac_zero   = ~|op[FRAC_W-1:0];
  assign unused_sign = op[DATA_W-1];

  assign is_nan  = exp_ones & ~frac_zero;
  assign is_inf  = exp_ones & frac_zero;
  assign is_zero = exp_zero & frac_zero;

endmodule
`endif

// File: rtl/iob_fp_div.sv
// Iterative floating-point divider: restoring mantissa division, one
// quotient bit per cycle, start/done handshake.
// Handshake: start_i is accepted only while busy_o=0 (state IDLE); busy_o
// rises the cycle after acceptance and falls together with the one-cycle
// done_o pulse; res_o and the flags are held until the next done_o.
// Optional feature macro: IOB_FP_DIV_SPECIAL_EN (NaN/Inf/zero handling on a
// one-cycle path). Without it every operand takes the normal path with the
// hidden bit forced to 1 and exception_o stays 0.
module iob_fp_div
  import iob_fp_div_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] res_o,
  output logic              overflow_o,
  output logic              underflow_o,
  output logic              exception_o,
  output state_t            dbg_state_o
);

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic                     sign_r;
  logic signed [EXPS_W-1:0] exp_r;
  logic [MAN_W:0]           rem_r;
  logic [MAN_W-1:0]         div_r;
  logic [Q_W-1:0]           q_r;
  logic [RND_W-1:0]         norm_r;

  logic                     sign_start;
  logic signed [EXPS_W-1:0] exp_start;
  logic [MAN_W:0]           rem_sub;
  logic                     rem_ge;
  logic [Q_W-1:0]           q_norm;
  logic [RND_W-1:0]         norm_next;
  logic [DATA_W-1:0]        rnd_res;
  logic                     rnd_ovf;
  logic                     rnd_unf;

  assign dbg_state_o = state;

  assign sign_start = op_a_i[DATA_W-1] ^ op_b_i[DATA_W-1];
  assign exp_start  = $signed({2'b00, op_a_i[DATA_W-2 -: EXP_W]})
                    - $signed({2'b00, op_b_i[DATA_W-2 -: EXP_W]})
                    + $signed(EXPS_W'(BIAS));

  // Restoring step: the remainder always stays below twice the divisor.
  assign rem_ge  = rem_r >= {1'b0, div_r};
  assign rem_sub = rem_r - {1'b0, div_r};

  // Quotient lies in (0.5, 2): at most one left shift normalises it.
  assign q_norm    = q_r[Q_W-1] ? q_r : {q_r[Q_W-2:0], 1'b0};
  assign norm_next = {q_norm[Q_W-1:2], (|q_norm[1:0]) | (|rem_r)};

  iob_fp_round u_round (
    .sign      (sign_r),
    .exponent  (exp_r),
    .mantissa  (norm_r),
    .res       (rnd_res),
    .overflow  (rnd_ovf),
    .underflow (rnd_unf)
  );

`ifdef IOB_FP_DIV_SPECIAL_EN
  logic              a_nan, a_inf, a_zero;
  logic              b_nan, b_inf, b_zero;
  logic              spec_hit;
  logic              spec_exc;
  logic [DATA_W-1:0] spec_res;
  logic              spec_r;
  logic              spec_exc_r;
  logic [DATA_W-1:0] spec_res_r;

  iob_fp_special u_spec_a (.op(op_a_i), .is_nan(a_nan), .is_inf(a_inf), .is_zero(a_zero));
  iob_fp_special u_spec_b (.op(op_b_i), .is_nan(b_nan), .is_inf(b_inf), .is_zero(b_zero));

  // Special-operand result selection, in priority order.
  always_comb begin
    spec_hit = 1'b1;
    spec_exc = 1'b0;
    spec_res = fp_zero(sign_start);
    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
      spec_res = fp_qnan();
      spec_exc = 1'b1;
    end else if (b_zero) begin
      spec_res = fp_inf(sign_start);
      spec_exc = 1'b1;
    end else if (a_inf) begin
      spec_res = fp_inf(sign_start);
    end else if (a_zero | b_inf) begin
      spec_res = fp_zero(sign_start);
    end else begin
      spec_hit = 1'b0;
    end
  end
`endif

  // Control FSM, iteration counter, divider datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      sign_r      <= 1'b0;
      exp_r       <= '0;
      rem_r       <= '0;
      div_r       <= '0;
      q_r         <= '0;
      norm_r      <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      res_o       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      exception_o <= 1'b0;
`ifdef IOB_FP_DIV_SPECIAL_EN
      spec_r      <= 1'b0;
      spec_exc_r  <= 1'b0;
      spec_res_r  <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            sign_r <= sign_start;
            exp_r  <= exp_start;
            rem_r  <= {2'b01, op_a_i[FRAC_W-1:0]};
            div_r  <= {1'b1, op_b_i[FRAC_W-1:0]};
            q_r    <= '0;
            cnt    <= '0;
            busy_o <= 1'b1;
`ifdef IOB_FP_DIV_SPECIAL_EN
            spec_r     <= spec_hit;
            spec_exc_r <= spec_exc;
            spec_res_r <= spec_res;
            state      <= spec_hit ? ST_ROUND : ST_DIV;
`else
            state  <= ST_DIV;
`endif
          end
        end
        ST_DIV: begin
          rem_r <= rem_ge ? (rem_sub << 1) : (rem_r << 1);
          q_r   <= {q_r[Q_W-2:0], rem_ge};
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITER - 1)) begin
            state <= ST_NORM;
          end
        end
        ST_NORM: begin
          norm_r <= norm_next;
          cnt    <= '0;
          if (!q_r[Q_W-1]) begin
            exp_r <= exp_r - EXPS_W'(1);
          end
          state <= ST_ROUND;
        end
        ST_ROUND: begin
          res_o       <= rnd_res;
          overflow_o  <= rnd_ovf;
          underflow_o <= rnd_unf;
          exception_o <= 1'b0;
`ifdef IOB_FP_DIV_SPECIAL_EN
          if (spec_r) begin
            res_o       <= spec_res_r;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            exception_o <= spec_exc_r;
          end
`endif
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_fp_div.sv
// Self-checking bench for iob_fp_div: directed vectors, randomized operands,
// ignored start while busy, back-to-back start, and mid-operation reset.
module tb_iob_fp_div;
  import iob_fp_div_pkg::*;

  localparam int LAT_NORMAL = 30;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] res;
  logic        ovf;
  logic        unf;
  logic        exc;
  state_t      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit started  = 1'b0;

  logic [34:0] exp_q[$];      // {res, overflow, underflow, exception}
  int          exp_cyc_q[$];  // cycle index at which done_o must be seen
  logic [34:0] held = '0;
  logic [31:0] ra, rb;

  iob_fp_div dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .op_a_i      (op_a),
    .op_b_i      (op_b),
    .busy_o      (busy),
    .done_o      (done),
    .res_o       (res),
    .overflow_o  (ovf),
    .underflow_o (unf),
    .exception_o (exc),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
`ifdef IOB_FP_DIV_SPECIAL_EN
  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
    bit a_zero, b_zero;
    a_zero = (a[30:0] == 31'h0);
    b_zero = (b[30:0] == 31'h0);
    return (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF) || a_zero || b_zero;
  endfunction
`endif

  function automatic int latency(input logic [31:0] a, input logic [31:0] b);
`ifdef IOB_FP_DIV_SPECIAL_EN
    if (is_special(a, b)) return 1;
`endif
    return LAT_NORMAL;
  endfunction

  // Exact quotient of the two significands, rounded to nearest-even by
  // comparing the exact remainder against half the divisor.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
    logic   sign;
    int     ea, eb, e;
    longint ma, mb, num, m, r;
    logic [31:0] q;
    sign = a[31] ^ b[31];
    ea   = int'(a[30:23]);
    eb   = int'(b[30:23]);
`ifdef IOB_FP_DIV_SPECIAL_EN
    begin
      bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      a_nan  = (ea == 255) && (a[22:0] != 0);
      b_nan  = (eb == 255) && (b[22:0] != 0);
      a_inf  = (ea == 255) && (a[22:0] == 0);
      b_inf  = (eb == 255) && (b[22:0] == 0);
      a_zero = (a[30:0] == 0);
      b_zero = (b[30:0] == 0);
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return {32'h7FC00000, 3'b001};
      if (b_zero) return {sign, 8'hFF, 23'h0, 3'b001};
      if (a_inf) return {sign, 8'hFF, 23'h0, 3'b000};
      if (a_zero || b_inf) return {sign, 31'h0, 3'b000};
    end
`endif
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    if (ma >= mb) begin
      num = ma << 23;
      e   = ea - eb + 127;
    end else begin
      num = ma << 24;
      e   = ea - eb + 126;
    end
    m = num / mb;
    r = num % mb;
    if ((2 * r > mb) || ((2 * r == mb) && (m % 2 == 1))) m = m + 1;
    if (m == (longint'(1) << 24)) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {sign, 8'hFF, 23'h0, 3'b100};
    if (e <= 0) return {sign, 31'h0, 3'b010};
    q = {sign, e[7:0], m[22:0]};
    return {q, 3'b000};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    int budget;
    int l;
    budget = 0;
    @(negedge clk);
    while (busy !== 1'b0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("launch_wait_idle", busy, 0);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    l = cyc + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.push_back(model(a, b));
    exp_cyc_q.push_back(l + latency(a, b));
  endtask

  // Start pulse while busy: must be ignored, so nothing is expected.
  task automatic poke(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_res"}, res, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_unf"}, unf, 0);
    check({tag, "_exc"}, exc, 0);
    check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (rst_n && started) begin
      bit busy_exp, done_exp;
      logic [34:0] e;
      busy_exp = (exp_q.size() > 0) && (cyc < exp_cyc_q[0]);
      done_exp = (exp_q.size() > 0) && (cyc == exp_cyc_q[0]);
      check("busy", busy, busy_exp);
      check("done", done, done_exp);
      if (exp_q.size() > 0 && cyc >= exp_cyc_q[0]) begin
        e = exp_q.pop_front();
        void'(exp_cyc_q.pop_front());
        check("res", res, e[34:3]);
        check("overflow", ovf, e[2]);
        check("underflow", unf, e[1]);
        check("exception", exc, e[0]);
        held = e;
      end else begin
        check("held", {res, ovf, unf, exc}, held);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    started = 1'b1;

    // Hand-computed values pin the model.
    check("pin_6_div_2", model(32'h40C00000, 32'h40000000), {32'h40400000, 3'b000});
    check("pin_1_div_3", model(32'h3F800000, 32'h40400000), {32'h3EAAAAAB, 3'b000});
    check("pin_m1_div_4", model(32'hBF800000, 32'h40800000), {32'hBE800000, 3'b000});
    check("pin_overflow", model(32'h7F000000, 32'h00800000), {32'h7F800000, 3'b100});
    check("pin_underflow", model(32'h00800000, 32'h7F000000), {32'h00000000, 3'b010});
`ifdef IOB_FP_DIV_SPECIAL_EN
    check("pin_1_div_0", model(32'h3F800000, 32'h00000000), {32'h7F800000, 3'b001});
    check("pin_0_div_0", model(32'h00000000, 32'h00000000), {32'h7FC00000, 3'b001});
`endif

    // 6/2 with an ignored start around edge 10, then back-to-back 1/3.
    launch(32'h40C00000, 32'h40000000);
    repeat (9) @(posedge clk);
    poke(32'h3F800000, 32'h40400000);
    launch(32'h3F800000, 32'h40400000);
    launch(32'hBF800000, 32'h40800000);
    launch(32'h7F000000, 32'h00800000);
    launch(32'h00800000, 32'h7F000000);
`ifdef IOB_FP_DIV_SPECIAL_EN
    launch(32'h3F800000, 32'h00000000);
    launch(32'h00000000, 32'h00000000);
    launch(32'hFF800000, 32'h40000000);
    launch(32'h00000000, 32'hC0A00000);
    launch(32'h7FC00001, 32'h3F800000);
    launch(32'h40000000, 32'h7F800000);
    launch(32'h7F800000, 32'h7F800000);
    launch(32'h40000000, 32'h3F800000);
`endif

    // Randomized operands; half of them near the bias to stay in range.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 0) begin
        ra[30:23] = 8'($urandom_range(100, 154));
        rb[30:23] = 8'($urandom_range(100, 154));
      end
`ifdef IOB_FP_DIV_SPECIAL_EN
      if (i % 8 == 3) rb = {rb[31], 31'h0};
`endif
      launch(ra, rb);
    end

    // Asynchronous reset around edge 15 of a division: abort, no done.
    launch(32'h40C00000, 32'h40000000);
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_cyc_q.delete();
    held = '0;
    check_reset_outputs("midop_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    launch(32'h40C00000, 32'h40000000);

    // Drain outstanding expectations with a bounded wait.
    begin
      int budget;
      budget = 0;
      while (exp_q.size() > 0 && budget < 100) begin
        @(negedge clk);
        budget++;
      end
      check("drain_pending", 64'(exp_q.size()), 0);
    end
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iob_fp_div.md
# iob_fp_div

Iterative IEEE-754-style floating-point divider, the inverse companion of the pipelined FP multiplier in the FP arithmetic library. It computes res_o = op_a_i / op_b_i with a restoring shift/subtract mantissa divider, one quotient bit per cycle, under a start/done handshake. Round-to-nearest-even is shared with the other FP units. Used by accelerator datapaths for normalisation and reciprocal stages, where area matters more than throughput.

## Interface
- DATA_W, 32, total float width
- EXP_W, 8, exponent width; MAN_W = DATA_W-EXP_W (mantissa incl. hidden bit), BIAS = 2^(EXP_W-1)-1, EXTRA = 3 (guard/round/sticky)
- clk_i  in  1  clock
- rst_n_i  in  1  reset; asynchronous and active-low
- start_i  in  1  launch division; sampled only when busy_o=0
- busy_o  out  1  high from the cycle after accepted start until done_o
- done_o  out  1  one-cycle pulse; res_o and flags valid
- op_a_i  in  DATA_W  dividend; sampled with start_i
- op_b_i  in  DATA_W  divisor; sampled with start_i
- res_o  out  DATA_W  quotient; registered; held until next done_o
- overflow_o  out  1  result exponent saturated to Inf; held with res_o
- underflow_o  out  1  result flushed to signed zero; held with res_o
- exception_o  out  1  finite/zero or invalid operation; held with res_o

## Operation
- Reset: all outputs 0, state IDLE, counter 0.
- States: IDLE -> DIV -> NORM -> ROUND -> IDLE.
- IDLE, start_i=1: latch sign = a_sign^b_sign, exp = Ea-Eb+BIAS (signed, EXP_W+2 bits), rem = {1,frac_a}, div = {1,frac_b}, cnt = 0; go to DIV.
- DIV: per cycle, if rem>=div then q bit=1, rem=(rem-div)<<1; else q bit=0, rem=rem<<1. MAN_W+EXTRA+1 iterations (28 at defaults), then NORM.
- NORM: quotient lies in (0.5,2). If q MSB=0, shift left 1 and exp-1. Sticky = LSB | (rem!=0).
- ROUND: shared round unit on {exp, MAN_W+EXTRA bits}. If final exp>=2^EXP_W-1, res=Inf(sign) and overflow_o=1. If exp<=0, res={sign,0...} and underflow_o=1. Otherwise pack. Register res_o and flags, pulse done_o, go to IDLE.
- start_i while busy_o=1 is ignored; operands are not re-sampled.
- Flags are cleared and rewritten on every done_o.
- rst_n_i low mid-operation aborts immediately; no done_o is produced.
- Back-to-back: start_i may be asserted in the cycle done_o is high, since the state is IDLE then.

## Timing
- Normal path: start sampled at edge 0; done_o high after edge MAN_W+EXTRA+3 (edge 30 at defaults); busy_o high from edge 0 through that edge.
- Special path (macro enabled): done_o and res_o valid after edge 1; busy_o high for exactly one cycle.
- Throughput: one division per MAN_W+EXTRA+4 cycles.

## Configuration
- IOB_FP_DIV_SPECIAL_EN defined: operands are classified on start.
  - NaN in either operand, 0/0 or Inf/Inf -> canonical NaN {0, all-ones exponent, 1, zeros}, exception_o=1.
  - finite/0 -> Inf(sign), exception_o=1.
  - Inf/finite -> Inf(sign).
  - 0/nonzero or finite/Inf -> signed zero.
  - All of these take the 1-cycle special path.
- Undefined: no classification. Every operand goes through the normal path with the hidden bit forced to 1. exception_o stays 0; overflow_o and underflow_o still operate.

## Structure
- Shared FP package: MAN_W, BIAS, EXTRA, and the canonical NaN and Inf constants/functions, shared with the multiplier and adder.
- Reuse iob_fp_special for classification (two instances, under the macro).
- One sub-module, iob_fp_round, for rounding and exponent adjust.
- FSM, counter and divider datapath stay in iob_fp_div.

## Test plan
- 0x40C00000 / 0x40000000 (6/2) -> res_o=0x40400000 with done_o after edge 30; all flags 0; busy_o high 30 cycles.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB (round-to-nearest-even exercised); 0xBF800000 / 0x40800000 -> 0xBE800000.
- 0x7F000000 / 0x00800000 -> 0x7F800000, overflow_o=1; 0x00800000 / 0x7F000000 -> 0x00000000, underflow_o=1.
- Macro enabled: 0x3F800000 / 0x00000000 -> 0x7F800000, exception_o=1, done_o after edge 1; 0x00000000 / 0x00000000 -> 0x7FC00000, exception_o=1.
- start_i pulsed with new operands at edge 10 of a division -> ignored; the first result is unchanged at edge 30; a start in the done_o cycle is accepted.
- rst_n_i asserted at edge 15 -> all outputs 0 asynchronously, no done_o; a new 6/2 after release completes normally.
